// File: rtl/multicycle_control.sv
// Moore sequencer for the multicycle MIPS datapath: steps each instruction through
// fetch/decode/execute/memory/write-back, stalls on mem_ready and counts retirements.
module multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [5:0]             opcode,
  input  logic                   mem_ready,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   MemtoReg,
  output logic                   IRWrite,
  output logic                   ALUSrcA,
  output logic                   RegWrite,
  output logic                   RegDst,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             ALUOp,
  output logic [1:0]             PCSource,
  output logic [3:0]             state,
  output logic                   trap,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_q, state_d;
  logic   retire;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      instr_count <= '0;
    else if (retire) instr_count <= instr_count + COUNT_WIDTH'(1);
  end

  assign state = state_q;

  // Everything stays at its zero default while reset is held low.
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    trap        = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          if (mem_ready) state_d = S_DECODE;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          case (opcode)
            OP_RTYPE:      state_d = S_R_EXEC;
            OP_LW, OP_SW:  state_d = S_MEM_ADDR;
            OP_BEQ:        state_d = S_BRANCH;
            OP_J:          state_d = S_JUMP;
            OP_ADDI:       state_d = S_ADDI_EXEC;
            default:       state_d = S_TRAP;
          endcase
        end
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        end
        S_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (mem_ready) state_d = S_MEM_WB;
        end
        S_MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_MEM_WRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_R_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
          state_d = S_R_WB;
        end
        S_R_WB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          retire      = 1'b1;
          state_d     = S_FETCH;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_ADDI_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = S_ADDI_WB;
        end
        S_ADDI_WB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        // TRAP and the unused encodings lock up until reset.
        default: trap = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle expectations queued by the
// stimulus process and checked by an independent monitor on the falling edge.
module tb_multicycle_control;

  localparam int CW = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic          IRWrite, ALUSrcA, RegWrite, RegDst, trap;
  logic [1:0]    ALUSrcB, ALUOp, PCSource;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;

  multicycle_control #(.COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .trap(trap), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,
  //  ALUSrcB,ALUOp,PCSource,trap}
  localparam logic [16:0] C_ZERO = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_F1   = 17'b1_0_0_1_0_0_1_0_0_0_01_00_00_0;
  localparam logic [16:0] C_F0   = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_DEC  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] C_MA   = 17'b0_0_0_0_0_0_0_1_0_0_10_00_00_0;
  localparam logic [16:0] C_MR   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MWB  = 17'b0_0_0_0_0_1_0_0_1_0_00_00_00_0;
  localparam logic [16:0] C_MW   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_REX  = 17'b0_0_0_0_0_0_0_1_0_0_00_10_00_0;
  localparam logic [16:0] C_RWB  = 17'b0_0_0_0_0_0_0_0_1_1_00_00_00_0;
  localparam logic [16:0] C_BR   = 17'b0_1_0_0_0_0_0_1_0_0_00_01_01_0;
  localparam logic [16:0] C_JMP  = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] C_AEX  = 17'b0_0_0_0_0_0_0_1_0_0_10_00_00_0;
  localparam logic [16:0] C_AWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [16:0] C_TRAP = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

  typedef struct packed {
    logic [3:0]    st;
    logic [16:0]   ctrl;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  exp_t          cur;
  logic [16:0]   act_ctrl;
  logic [CW-1:0] exp_cnt;
  int            checks = 0;
  int            errors = 0;

  assign act_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                     ALUSrcA, RegWrite, RegDst, ALUSrcB, ALUOp, PCSource, trap};

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      if (state !== cur.st) begin
        errors++;
        $display("FAIL state @%0t: got %0d expected %0d", $time, state, cur.st);
      end
      checks++;
      if (act_ctrl !== cur.ctrl) begin
        errors++;
        $display("FAIL controls @%0t (state %0d): got %b expected %b", $time, cur.st, act_ctrl, cur.ctrl);
      end
      checks++;
      if (instr_count !== cur.cnt) begin
        errors++;
        $display("FAIL instr_count @%0t: got %0d expected %0d", $time, instr_count, cur.cnt);
      end
    end
  end

  // One clock cycle: apply inputs, queue what the DUT must show, then advance.
  task automatic cyc(input logic [5:0] op, input logic mr, input logic [3:0] st,
                     input logic [16:0] c, input logic ret);
    opcode    = op;
    mem_ready = mr;
    sb.push_back('{st: st, ctrl: c, cnt: exp_cnt});
    @(posedge clock); #1;
    if (ret) exp_cnt = exp_cnt + 1'b1;
  endtask

  // Reset held low for one cycle, asserted away from the clock edge.
  task automatic rst_cyc(input logic [5:0] op, input logic mr);
    reset     = 1'b0;
    opcode    = op;
    mem_ready = mr;
    exp_cnt   = '0;
    sb.push_back('{st: 4'd0, ctrl: C_ZERO, cnt: exp_cnt});
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic do_j();
    cyc(6'b000010, 1'b1, 4'd0, C_F1,  1'b0);
    cyc(6'b000010, 1'b1, 4'd1, C_DEC, 1'b0);
    cyc(6'b000010, 1'b1, 4'd9, C_JMP, 1'b1);
  endtask

  initial begin
    reset     = 1'b0;
    opcode    = 6'b000000;
    mem_ready = 1'b1;
    exp_cnt   = '0;
    @(posedge clock); #1;
    rst_cyc(6'b000000, 1'b1);
    rst_cyc(6'b100011, 1'b0);

    // R-type, mem_ready high
    cyc(6'b000000, 1'b1, 4'd0, C_F1,  1'b0);
    cyc(6'b000000, 1'b1, 4'd1, C_DEC, 1'b0);
    cyc(6'b000000, 1'b1, 4'd6, C_REX, 1'b0);
    cyc(6'b000000, 1'b1, 4'd7, C_RWB, 1'b1);

    // lw with two stall cycles in MEM_READ
    cyc(6'b100011, 1'b1, 4'd0, C_F1,  1'b0);
    cyc(6'b100011, 1'b1, 4'd1, C_DEC, 1'b0);
    cyc(6'b100011, 1'b1, 4'd2, C_MA,  1'b0);
    cyc(6'b100011, 1'b0, 4'd3, C_MR,  1'b0);
    cyc(6'b100011, 1'b0, 4'd3, C_MR,  1'b0);
    cyc(6'b100011, 1'b1, 4'd3, C_MR,  1'b0);
    cyc(6'b100011, 1'b1, 4'd4, C_MWB, 1'b1);

    // sw with three stall cycles in FETCH
    cyc(6'b101011, 1'b0, 4'd0, C_F0,  1'b0);
    cyc(6'b101011, 1'b0, 4'd0, C_F0,  1'b0);
    cyc(6'b101011, 1'b0, 4'd0, C_F0,  1'b0);
    cyc(6'b101011, 1'b1, 4'd0, C_F1,  1'b0);
    cyc(6'b101011, 1'b1, 4'd1, C_DEC, 1'b0);
    cyc(6'b101011, 1'b1, 4'd2, C_MA,  1'b0);
    cyc(6'b101011, 1'b1, 4'd5, C_MW,  1'b1);

    // sw stalled in MEM_WRITE: only the ready cycle retires
    cyc(6'b101011, 1'b1, 4'd0, C_F1,  1'b0);
    cyc(6'b101011, 1'b1, 4'd1, C_DEC, 1'b0);
    cyc(6'b101011, 1'b0, 4'd2, C_MA,  1'b0);
    cyc(6'b101011, 1'b0, 4'd5, C_MW,  1'b0);
    cyc(6'b101011, 1'b1, 4'd5, C_MW,  1'b1);

    // addi with mem_ready low outside the memory states
    cyc(6'b001000, 1'b1, 4'd0,  C_F1,  1'b0);
    cyc(6'b001000, 1'b0, 4'd1,  C_DEC, 1'b0);
    cyc(6'b001000, 1'b0, 4'd10, C_AEX, 1'b0);
    cyc(6'b001000, 1'b0, 4'd11, C_AWB, 1'b1);

    // beq then j from a fresh counter
    rst_cyc(6'b000100, 1'b1);
    cyc(6'b000100, 1'b1, 4'd0, C_F1,  1'b0);
    cyc(6'b000100, 1'b1, 4'd1, C_DEC, 1'b0);
    cyc(6'b000100, 1'b1, 4'd8, C_BR,  1'b1);
    do_j();

    // unsupported opcode traps; inputs toggle while trapped
    cyc(6'b111111, 1'b1, 4'd0, C_F1,  1'b0);
    cyc(6'b111111, 1'b1, 4'd1, C_DEC, 1'b0);
    for (int i = 0; i < 20; i++)
      cyc((i % 2 == 0) ? 6'b000000 : 6'b100011, i[0], 4'd12, C_TRAP, 1'b0);
    rst_cyc(6'b000000, 1'b1);
    cyc(6'b000000, 1'b1, 4'd0, C_F1, 1'b0);
    cyc(6'b000000, 1'b1, 4'd1, C_DEC, 1'b0);
    cyc(6'b000000, 1'b1, 4'd6, C_REX, 1'b0);
    cyc(6'b000000, 1'b1, 4'd7, C_RWB, 1'b1);

    // 1000 retirements, then reset while stalled in MEM_READ
    rst_cyc(6'b000010, 1'b1);
    for (int i = 0; i < 1000; i++) do_j();
    cyc(6'b100011, 1'b1, 4'd0, C_F1,  1'b0);
    cyc(6'b100011, 1'b1, 4'd1, C_DEC, 1'b0);
    cyc(6'b100011, 1'b1, 4'd2, C_MA,  1'b0);
    cyc(6'b100011, 1'b0, 4'd3, C_MR,  1'b0);
    rst_cyc(6'b100011, 1'b0);
    cyc(6'b000000, 1'b1, 4'd0, C_F1,  1'b0);
    cyc(6'b000000, 1'b1, 4'd1, C_DEC, 1'b0);
    cyc(6'b000000, 1'b1, 4'd6, C_REX, 1'b0);
    cyc(6'b000000, 1'b1, 4'd7, C_RWB, 1'b1);

    // counter wraps modulo 2^CW: 1 + 1025 = 1026 -> 2
    for (int i = 0; i < 1025; i++) do_j();
    cyc(6'b000000, 1'b1, 4'd0, C_F1, 1'b0);

    @(negedge clock); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencer for the MIPS datapath. It replaces the single-cycle decode path with a Moore state machine that steps each instruction through fetch, decode, execute, memory and write-back cycles. The datapath can then share one ALU and one unified instruction/data memory. It drives every datapath mux select and write enable, stalls on a memory-ready handshake, counts retired instructions and traps on unsupported opcodes.

## Interface
- COUNT_WIDTH, 32, width of the retired-instruction counter

- clock  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low; while low, state = FETCH, counter = 0 and all outputs are forced to 0
- opcode  input  6  instruction[31:26], taken from the instruction register
- mem_ready  input  1  memory has completed the current read/write this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls
- ALUSrcB  output  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALUOp  output  2  to ula_control: 00 = add, 01 = subtract, 10 = use funct field
- PCSource  output  2  00 = ALU result, 01 = ALUOut register, 10 = jump target
- state  output  4  current state encoding, for debug
- trap  output  1  high while in TRAP
- instr_count  output  COUNT_WIDTH  number of retired instructions

## Operation
State encodings, with the outputs asserted in each state. Any output not listed is 0.
- 0 FETCH: MemRead=1, ALUSrcB=01. IRWrite and PCWrite equal mem_ready. Go to DECODE when mem_ready=1, otherwise stay.
- 1 DECODE: ALUSrcB=11. Next state depends on opcode:
  - 000000 → R_EXEC
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDI_EXEC
  - any other opcode → TRAP
- 2 MEM_ADDR: ALUSrcA=1, ALUSrcB=10. Go to MEM_READ if opcode=100011, otherwise MEM_WRITE.
- 3 MEM_READ: MemRead=1, IorD=1. Go to MEM_WB when mem_ready=1, otherwise stay.
- 4 MEM_WB: RegWrite=1, MemtoReg=1. Go to FETCH.
- 5 MEM_WRITE: MemWrite=1, IorD=1. Go to FETCH when mem_ready=1, otherwise stay.
- 6 R_EXEC: ALUSrcA=1, ALUOp=10. Go to R_WB.
- 7 R_WB: RegWrite=1, RegDst=1. Go to FETCH.
- 8 BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01. Go to FETCH.
- 9 JUMP: PCWrite=1, PCSource=10. Go to FETCH.
- 10 ADDI_EXEC: ALUSrcA=1, ALUSrcB=10. Go to ADDI_WB.
- 11 ADDI_WB: RegWrite=1. Go to FETCH.
- 12 TRAP: all controls 0, trap=1. Stays in TRAP until reset. opcode and mem_ready are ignored.

Encodings 13–15 are unreachable. If one is ever entered, it behaves as TRAP.

Outputs are combinational decodes of the state register (Moore). The only exception is that IRWrite and PCWrite in FETCH are gated by mem_ready.

opcode is sampled only in DECODE and MEM_ADDR. The IR holds it stable from the end of FETCH onward.

instr_count increments by 1 on the edge that leaves a final state:
- MEM_WB, R_WB, BRANCH, JUMP and ADDI_WB always count.
- MEM_WRITE counts only when mem_ready=1.
- The counter wraps modulo 2^COUNT_WIDTH.
- A trapped instruction is never counted.

## Timing
- Instruction latency with mem_ready tied high:
  - beq: 3 cycles
  - j: 3 cycles
  - R-type: 4 cycles
  - addi: 4 cycles
  - sw: 4 cycles
  - lw: 5 cycles
- Each cycle mem_ready is low in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- While stalled, MemRead/MemWrite and IorD are held constant and no register, PC or IR write occurs.
- mem_ready is ignored in every state other than FETCH, MEM_READ and MEM_WRITE.
- Asserting reset mid-instruction (any state, including a stall) immediately forces outputs to 0 and the state to FETCH, and clears instr_count.
- On the first rising edge after reset deasserts, FETCH outputs are active. An instruction aborted by reset is not counted.

## Test plan
- Reset, then release with mem_ready=1 and opcode=000000 → state sequence 0,1,6,7,0. RegWrite=1 and RegDst=1 only in state 7. instr_count=1 after 4 cycles.
- lw (100011) with mem_ready low for 2 cycles in MEM_READ → states 0,1,2,3,3,3,4,0. MemRead=1 and IorD=1 held for all three cycles in state 3. instr_count=1 after 7 cycles.
- sw (101011) with mem_ready low for 3 cycles in FETCH → IRWrite=PCWrite=0 for 3 cycles, then 1 for one cycle. MemWrite=1 in state 5. Total 7 cycles.
- beq (000100) then j (000010) → BRANCH shows PCWriteCond=1, ALUOp=01, PCSource=01. JUMP shows PCWrite=1, PCSource=10. instr_count=2 after 6 cycles.
- opcode=111111 → TRAP after DECODE. trap=1 and instr_count stays unchanged for 20 cycles despite opcode and mem_ready toggling. A reset pulse returns the block to FETCH with trap=0.
- Reset pulse while in MEM_READ after 1000 retired instructions → all outputs 0 while reset is low, instr_count=0. The next instruction starts from FETCH.
